// File: rtl/mips_control_unit_if.sv
// Control bundle between the multicycle MIPS control unit and its datapath.
// The master side decodes opcode/funct and drives every select and enable.
interface mips_control_unit_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic [3:0] state;
   logic       MemtoReg;
   logic       RegDst;
   logic       IorD;
   logic       ALUSrcA;
   logic       IRWrite;
   logic       MemWrite;
   logic       PCWrite;
   logic       BranchEQ;
   logic       BranchNE;
   logic       RegWrite;
   logic [1:0] PCSrc;
   logic [1:0] ALUSrcB;
   logic [2:0] ALUControl;

   modport master (
      input  opcode, funct,
      output state, MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
             BranchEQ, BranchNE, RegWrite, PCSrc, ALUSrcB, ALUControl
   );

   modport slave (
      output opcode, funct,
      input  state, MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
             BranchEQ, BranchNE, RegWrite, PCSrc, ALUSrcB, ALUControl
   );
endinterface

// File: rtl/mips_control_unit.sv
// Multicycle MIPS sequencing FSM (Moore) plus ALU decoder.
//  state       | meaning
//  0  FETCH    | load IR, PC <= PC+4
//  1  DECODE   | read regs, precompute branch target
//  2  MEMADR   | lw/sw address = A + imm
//  3  MEMRD    | read data memory
//  4  MEMWB    | write loaded word to rt
//  5  MEMWR    | write B to memory
//  6  EXEC     | R-type ALU op
//  7  ALUWB    | write ALU result to rd
//  8  BEQ      | branch if equal
//  9  ADDIEX   | A + imm
//  10 ADDIWB   | write sum to rt
//  11 JUMP     | PC <= jump target
//  12 BNE      | branch if not equal
module mips_control_unit (
   input  logic                clock_i,
   input  logic                reset_i,
   mips_control_unit_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
      S_BEQ    = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
      S_BNE    = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t     state_q, state_d;
   logic       mem_to_reg, reg_dst, i_or_d, alu_src_a, ir_write, mem_write;
   logic       pc_write, branch_eq, branch_ne, reg_write;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic [2:0] alu_control;

   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= S_FETCH;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d    = S_FETCH;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      i_or_d     = 1'b0;
      alu_src_a  = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      pc_write   = 1'b0;
      branch_eq  = 1'b0;
      branch_ne  = 1'b0;
      reg_write  = 1'b0;
      pc_src     = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (bus.opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXEC;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               OP_BNE:       state_d = S_BNE;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            // Only lw/sw reach here; anything else is treated as a store target.
            state_d   = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            i_or_d  = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch_eq = 1'b1;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: reg_write = 1'b1;
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         S_BNE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch_ne = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_comb begin
      alu_control = 3'b010;
      case (alu_op)
         2'b01: alu_control = 3'b110;
         2'b10: begin
            case (bus.funct)
               6'b100010: alu_control = 3'b110;
               6'b100100: alu_control = 3'b000;
               6'b100101: alu_control = 3'b001;
               6'b101010: alu_control = 3'b111;
               default:   alu_control = 3'b010;
            endcase
         end
         default: alu_control = 3'b010;
      endcase
   end

   assign bus.state      = state_q;
   assign bus.MemtoReg   = mem_to_reg;
   assign bus.RegDst     = reg_dst;
   assign bus.IorD       = i_or_d;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.IRWrite    = ir_write;
   assign bus.MemWrite   = mem_write;
   assign bus.PCWrite    = pc_write;
   assign bus.BranchEQ   = branch_eq;
   assign bus.BranchNE   = branch_ne;
   assign bus.RegWrite   = reg_write;
   assign bus.PCSrc      = pc_src;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ALUControl = alu_control;
endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for the multicycle MIPS control unit: walks every instruction
// class through its state sequence and checks the full control word each cycle.
module tb_mips_control_unit;
   logic clock_i = 1'b0;
   logic reset_i = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   mips_control_unit_if bus ();

   mips_control_unit dut (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .bus     (bus.master)
   );

   always #5 clock_i = ~clock_i;

   // {state, MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
   //  BranchEQ, BranchNE, RegWrite, PCSrc, ALUSrcB, ALUControl}
   logic [20:0] obs;
   assign obs = {bus.state, bus.MemtoReg, bus.RegDst, bus.IorD, bus.ALUSrcA,
                 bus.IRWrite, bus.MemWrite, bus.PCWrite, bus.BranchEQ,
                 bus.BranchNE, bus.RegWrite, bus.PCSrc, bus.ALUSrcB, bus.ALUControl};

   function automatic logic [20:0] cw(input logic [3:0] st, input logic mtr, input logic rd,
                                      input logic iord, input logic srca, input logic irw,
                                      input logic mw, input logic pcw, input logic beq,
                                      input logic bne, input logic rw, input logic [1:0] pcs,
                                      input logic [1:0] srcb, input logic [2:0] aluc);
      return {st, mtr, rd, iord, srca, irw, mw, pcw, beq, bne, rw, pcs, srcb, aluc};
   endfunction

   logic [20:0] V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_MEMWR, V_ALUWB;
   logic [20:0] V_BEQ, V_ADDIEX, V_ADDIWB, V_JUMP, V_BNE;

   task automatic tick();
      @(posedge clock_i);
      @(negedge clock_i);
   endtask

   task automatic chk(input string tag, input logic [20:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic [20:0] exp);
      tick();
      chk(tag, exp);
   endtask

   logic [5:0] r_funct [6];
   logic [2:0] r_aluc  [6];

   initial begin
      //              st     mtr  rd   iord srca irw  mw   pcw  beq  bne  rw   pcs    srcb   aluc
      V_FETCH  = cw(4'd0,  0,   0,   0,   0,   1,   0,   1,   0,   0,   0,   2'b00, 2'b01, 3'b010);
      V_DECODE = cw(4'd1,  0,   0,   0,   0,   0,   0,   0,   0,   0,   0,   2'b00, 2'b11, 3'b010);
      V_MEMADR = cw(4'd2,  0,   0,   0,   1,   0,   0,   0,   0,   0,   0,   2'b00, 2'b10, 3'b010);
      V_MEMRD  = cw(4'd3,  0,   0,   1,   0,   0,   0,   0,   0,   0,   0,   2'b00, 2'b00, 3'b010);
      V_MEMWB  = cw(4'd4,  1,   0,   0,   0,   0,   0,   0,   0,   0,   1,   2'b00, 2'b00, 3'b010);
      V_MEMWR  = cw(4'd5,  0,   0,   1,   0,   0,   1,   0,   0,   0,   0,   2'b00, 2'b00, 3'b010);
      V_ALUWB  = cw(4'd7,  0,   1,   0,   0,   0,   0,   0,   0,   0,   1,   2'b00, 2'b00, 3'b010);
      V_BEQ    = cw(4'd8,  0,   0,   0,   1,   0,   0,   0,   1,   0,   0,   2'b01, 2'b00, 3'b110);
      V_ADDIEX = cw(4'd9,  0,   0,   0,   1,   0,   0,   0,   0,   0,   0,   2'b00, 2'b10, 3'b010);
      V_ADDIWB = cw(4'd10, 0,   0,   0,   0,   0,   0,   0,   0,   0,   1,   2'b00, 2'b00, 3'b010);
      V_JUMP   = cw(4'd11, 0,   0,   0,   0,   0,   0,   1,   0,   0,   0,   2'b10, 2'b00, 3'b010);
      V_BNE    = cw(4'd12, 0,   0,   0,   1,   0,   0,   0,   0,   1,   0,   2'b01, 2'b00, 3'b110);

      r_funct[0] = 6'b100010; r_aluc[0] = 3'b110;
      r_funct[1] = 6'b101010; r_aluc[1] = 3'b111;
      r_funct[2] = 6'b100000; r_aluc[2] = 3'b010;
      r_funct[3] = 6'b100100; r_aluc[3] = 3'b000;
      r_funct[4] = 6'b100101; r_aluc[4] = 3'b001;
      r_funct[5] = 6'b000111; r_aluc[5] = 3'b010;

      bus.opcode = 6'b111111;
      bus.funct  = 6'b000000;
      reset_i    = 1'b1;
      tick();
      chk("reset", V_FETCH);
      tick();
      chk("reset_hold", V_FETCH);

      // lw
      bus.opcode = 6'b100011;
      reset_i    = 1'b0;
      step("lw.decode", V_DECODE);
      step("lw.memadr", V_MEMADR);
      step("lw.memrd",  V_MEMRD);
      step("lw.memwb",  V_MEMWB);
      step("lw.fetch",  V_FETCH);

      // sw
      bus.opcode = 6'b101011;
      step("sw.decode", V_DECODE);
      step("sw.memadr", V_MEMADR);
      step("sw.memwr",  V_MEMWR);
      step("sw.fetch",  V_FETCH);

      // R-type across funct table, including an unrecognised funct
      bus.opcode = 6'b000000;
      for (int i = 0; i < 6; i++) begin
         bus.funct = r_funct[i];
         step("r.decode", V_DECODE);
         step("r.exec", cw(4'd6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, r_aluc[i]));
         step("r.aluwb", V_ALUWB);
         step("r.fetch", V_FETCH);
      end

      // beq / bne; funct left at a non-sub code to show ALUOp 01 ignores it
      bus.funct  = 6'b100101;
      bus.opcode = 6'b000100;
      step("beq.decode", V_DECODE);
      step("beq.exec",   V_BEQ);
      step("beq.fetch",  V_FETCH);
      bus.opcode = 6'b000101;
      step("bne.decode", V_DECODE);
      step("bne.exec",   V_BNE);
      step("bne.fetch",  V_FETCH);

      // addi
      bus.opcode = 6'b001000;
      step("addi.decode", V_DECODE);
      step("addi.ex",     V_ADDIEX);
      step("addi.wb",     V_ADDIWB);
      step("addi.fetch",  V_FETCH);

      // j
      bus.opcode = 6'b000010;
      step("j.decode", V_DECODE);
      step("j.jump",   V_JUMP);
      step("j.fetch",  V_FETCH);

      // illegal opcode returns straight to fetch
      bus.opcode = 6'b111111;
      step("ill.decode", V_DECODE);
      step("ill.fetch",  V_FETCH);

      // reset mid-instruction, then resume with FETCH -> DECODE
      bus.opcode = 6'b100011;
      step("rst.decode", V_DECODE);
      step("rst.memadr", V_MEMADR);
      step("rst.memrd",  V_MEMRD);
      reset_i = 1'b1;
      step("rst.fetch",  V_FETCH);
      reset_i = 1'b0;
      step("rst.resume", V_DECODE);
      step("rst.memadr2", V_MEMADR);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
